step_shaper: RTL and testbench
==============================

STEP_SHAPER -- requirements
Module: step_shaper

Interface
REQ-001: Parameter PULSE_W, default 200, step_out high time in clk cycles (>=1).
REQ-002: Parameter SPACE_W, default 200, step_out minimum low time after each pulse, in cycles (>=1); also the DIR hold time.
REQ-003: Parameter DIR_SETUP, default 100, cycles dir_out is stable before a step_out rising edge (>=1).
REQ-004: Parameter PEND_BITS, default 4, width of the signed pending-step counter.
REQ-005: clk  in  1  system clock, the same clock as the stepgen driving this block.
REQ-006: rst_n  in  1  reset; asynchronous, active-low.
REQ-007: enable  in  1  joint enable from the SPI frame.
REQ-008: step_in  in  1  raw step from stepgen; each rising edge is one step request.
REQ-009: dir_in  in  1  raw direction from stepgen; 1 = positive, sampled in the cycle of the step_in rising edge.
REQ-010: step_out  out  1  driver-timed step pulse.
REQ-011: dir_out  out  1  driver-timed direction.
REQ-012: pending  out  PEND_BITS  signed net count of queued, not-yet-emitted steps.
REQ-013: overflow  out  1  sticky flag; a request was dropped at saturation.
REQ-014: position  out  32  signed count of emitted steps, used as jointFeedback.
REQ-015: busy  out  1  high whenever the state is not IDLE.

Function
REQ-016: The block shall detect a request in cycle 0 when step_in=1 and step_in was 0 in the previous cycle; request value is +1 if dir_in=1, else -1.
REQ-017: pending shall update at the end of cycle 0 as net += request, with no request recorded while enable=0.
REQ-018: pending shall saturate at +(2^(PEND_BITS-1)-1) and -(2^(PEND_BITS-1)-1); a request that would exceed the limit is dropped and sets overflow.
REQ-019: The state machine shall have four states: IDLE, SETUP, HIGH and LOW.
REQ-020: In IDLE with pending!=0 and sign(pending) matching dir_out, the next state shall be HIGH; with the sign mismatched, dir_out shall take the new sign and the next state shall be SETUP.
REQ-021: SETUP shall last DIR_SETUP cycles and then go to HIGH.
REQ-022: If pending becomes 0 during SETUP, the FSM shall return to IDLE with no pulse.
REQ-023: If the sign of pending flips during SETUP, dir_out shall follow it and the SETUP count shall restart.
REQ-024: On entry to HIGH, step_out shall go to 1, pending shall move one step toward 0, and position shall change by +1 if dir_out=1, else -1.
REQ-025: If a request and an emission occur in the same cycle, both effects shall apply.
REQ-026: HIGH shall last PULSE_W cycles, followed by LOW for SPACE_W cycles with step_out=0, then IDLE.
REQ-027: dir_out shall change only on the IDLE->SETUP transition.
REQ-028: From an IDLE request with dir matching, latency shall be fixed: step_out is first high in cycle 2.
REQ-029: position shall wrap modulo 2^32.
REQ-030: When enable falls, pending shall clear to 0 in the next cycle and SETUP shall abort to IDLE; an in-progress HIGH/LOW sequence shall complete in full.
REQ-031: overflow shall clear only on reset.

Reset
REQ-032: While rst_n=0, the block shall force state=IDLE, step_out=0, dir_out=0, pending=0, overflow=0, position=0, busy=0, and the step_in history register to 1, so that a high step_in at release is not a request.
REQ-033: Reset mid-pulse shall drop step_out to 0 immediately, without waiting for clk.

Structure
REQ-034: The state encoding and the saturation limit function shall live in the shared firmware package, stepper_pkg.
REQ-035: One sub-module is natural: phase_timer, a loadable down-counter with a done flag, shared by SETUP, HIGH and LOW.
REQ-036: The top-level integration shall place step_shaper between each stepgen STP/DIR output and its pins, and shall drive jointFeedback from position.

Verification (PULSE_W=4, SPACE_W=4, DIR_SETUP=8, PEND_BITS=4)
REQ-037: Reset, enable=1, one +1 request -> dir_out=1 in cycle 2, step_out high in cycles 10-13, position=1, pending=0, busy low in cycle 18.
REQ-038: Three +1 requests 2 cycles apart with dir_out already 1 -> three 4-high/4-low pulses back to back, position +3, no SETUP.
REQ-039: PULSE_W=SPACE_W=20 and ten +1 requests 2 cycles apart -> pending peaks at 7, overflow=1, total emitted steps = 1 + 7 = 8 (one emission overlaps the burst).
REQ-040: After reset, a +1 request then a -1 request 3 cycles later (inside SETUP) -> pending=0, return to IDLE, no step_out pulse, position=0.
REQ-041: enable dropped in cycle 1 of HIGH with pending=3 -> pulse completes 4 high + 4 low, pending=0 next cycle, no further pulses.
REQ-042: rst_n asserted mid-HIGH -> step_out=0 asynchronously, all outputs at reset values, and no request while step_in is held high after release.

Source files
------------

// File: rtl/stepper_pkg.sv
// Shared stepper definitions: shaper state encoding, timer width, pending-count saturation limit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    // Width of the phase timer; wide enough for pulse/space/setup lengths up to 65536 cycles.
    localparam int TIMER_W = 16;

    // Largest magnitude a signed pending counter of 'bits' width may hold (symmetric range).
    function automatic int sat_limit(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the SETUP, HIGH and LOW phases of the step shaper.
// Latency: loading N-1 keeps o_done low for N-1 cycles, so a phase lasts exactly N cycles.
// Backpressure: none; a load always wins over counting.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Count down to zero and park there; a load restarts the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/step_shaper.sv
// Re-times raw stepgen STEP/DIR into driver-legal pulses with DIR setup/hold, queueing requests.
// Latency: request with matching direction gives step_out high two cycles later; else +DIR_SETUP.
// Backpressure: none upstream; requests beyond the pending limit are dropped and flag overflow.
module step_shaper
    import stepper_pkg::*;
#(
    parameter int PULSE_W   = 200,
    parameter int SPACE_W   = 200,
    parameter int DIR_SETUP = 100,
    parameter int PEND_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        step_in,
    input  logic                        dir_in,
    output logic                        step_out,
    output logic                        dir_out,
    output logic signed [PEND_BITS-1:0] pending,
    output logic                        overflow,
    output logic signed [31:0]          position,
    output logic                        busy
);

    localparam int LIM = sat_limit(PEND_BITS);
    localparam logic [TIMER_W-1:0] LD_SETUP = TIMER_W'(DIR_SETUP - 1);
    localparam logic [TIMER_W-1:0] LD_HIGH  = TIMER_W'(PULSE_W - 1);
    localparam logic [TIMER_W-1:0] LD_LOW   = TIMER_W'(SPACE_W - 1);

    state_t                        r_state;
    logic                          r_step_d;
    logic                          r_dir;
    logic                          r_step_out;
    logic signed [PEND_BITS-1:0]   r_pend;
    logic                          r_ovf;
    logic signed [31:0]            r_pos;

    state_t                        w_state_nxt;
    logic                          w_dir_nxt;
    logic                          w_load;
    logic [TIMER_W-1:0]            w_load_val;
    logic                          w_emit;
    logic                          w_done;
    logic                          w_pend_nz;
    logic                          w_pend_pos;
    logic                          w_req;
    logic                          w_drop;
    int                            w_pend_i;
    int                            w_after;
    int                            w_sum;
    logic signed [PEND_BITS-1:0]   w_pend_nxt;

    assign w_pend_nz  = (r_pend != '0);
    assign w_pend_pos = ~r_pend[PEND_BITS-1];

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Next state, direction change, timer loads and the emit strobe (fires on entry to HIGH).
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_emit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_pend_nz) begin
                    w_load = 1'b1;
                    if (w_pend_pos == r_dir) begin
                        w_state_nxt = ST_HIGH;
                        w_emit      = 1'b1;
                        w_load_val  = LD_HIGH;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_dir_nxt   = w_pend_pos;
                        w_load_val  = LD_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (!enable || !w_pend_nz) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_pend_pos != r_dir) begin
                    // Queue reversed while waiting: follow it and restart the setup window.
                    w_dir_nxt  = w_pend_pos;
                    w_load     = 1'b1;
                    w_load_val = LD_SETUP;
                end else if (w_done) begin
                    w_state_nxt = ST_HIGH;
                    w_emit      = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = LD_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_done) begin
                    w_state_nxt = ST_LOW;
                    w_load      = 1'b1;
                    w_load_val  = LD_LOW;
                end
            end
            ST_LOW: begin
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pending update: emission moves toward zero, then the request is added unless it would saturate.
    always_comb begin
        w_pend_i = 32'(r_pend);
        w_after  = w_pend_i - (w_emit ? (r_dir ? 1 : -1) : 0);
        w_sum    = w_after + (dir_in ? 1 : -1);
        w_req    = enable & step_in & ~r_step_d;
        w_drop   = w_req && ((w_sum > LIM) || (w_sum < -LIM));
        if (!enable) begin
            w_pend_nxt = '0;
        end else if (w_req && !w_drop) begin
            w_pend_nxt = PEND_BITS'(w_sum);
        end else begin
            w_pend_nxt = PEND_BITS'(w_after);
        end
    end

    // State, direction, pulse output and the step counters; reset also clears step_out at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step_d   <= 1'b1;
            r_dir      <= 1'b0;
            r_step_out <= 1'b0;
            r_pend     <= '0;
            r_ovf      <= 1'b0;
            r_pos      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_d   <= step_in;
            r_dir      <= w_dir_nxt;
            r_step_out <= (w_state_nxt == ST_HIGH);
            r_pend     <= w_pend_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_emit) begin
                r_pos <= r_pos + (r_dir ? 32'sd1 : -32'sd1);
            end
        end
    end

    assign step_out = r_step_out;
    assign dir_out  = r_dir;
    assign pending  = r_pend;
    assign overflow = r_ovf;
    assign position = r_pos;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_step_shaper.sv
// Randomised and directed bench for step_shaper against an in-bench timing model.
// Latency: model is cycle-exact; outputs checked every cycle at the falling edge.
// Backpressure: n/a.
module tb_step_shaper;

    localparam int P   = 4;
    localparam int S   = 4;
    localparam int D   = 8;
    localparam int PB  = 4;
    localparam int LIM = 7;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               enable;
    logic               step_in;
    logic               dir_in;
    logic               step_out;
    logic               dir_out;
    logic signed [3:0]  pending;
    logic               overflow;
    logic signed [31:0] position;
    logic               busy;

    step_shaper #(
        .PULSE_W   (P),
        .SPACE_W   (S),
        .DIR_SETUP (D),
        .PEND_BITS (PB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .step_in  (step_in),
        .dir_in   (dir_in),
        .step_out (step_out),
        .dir_out  (dir_out),
        .pending  (pending),
        .overflow (overflow),
        .position (position),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: pending as an integer, a single countdown for the whole HIGH+LOW pulse
    // and a countdown for the remaining direction-setup wait.
    int          m_pend;
    bit          m_dir;
    bit          m_ovf;
    bit          m_prev;
    logic [31:0] m_pos;
    int          m_pulse_left;
    int          m_setup_left;

    // Pulse statistics observed on the DUT, used by directed checks.
    int n_rise;
    int n_high;
    int first_rise;
    bit so_prev;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pend       = 0;
        m_dir        = 1'b0;
        m_ovf        = 1'b0;
        m_prev       = 1'b1;
        m_pos        = '0;
        m_pulse_left = 0;
        m_setup_left = 0;
    endtask

    task automatic model_adv();
        bit emit;
        bit req;
        bit ndir;
        int p;
        int s;
        int npl;
        int nsl;
        emit = 1'b0;
        ndir = m_dir;
        npl  = 0;
        nsl  = 0;
        if (m_pulse_left > 0) begin
            npl = m_pulse_left - 1;
        end else if (m_setup_left > 0) begin
            if (!enable || m_pend == 0) begin
                nsl = 0;
            end else if ((m_pend > 0) != m_dir) begin
                ndir = (m_pend > 0);
                nsl  = D;
            end else if (m_setup_left == 1) begin
                emit = 1'b1;
                npl  = P + S;
            end else begin
                nsl = m_setup_left - 1;
            end
        end else if (enable && m_pend != 0) begin
            if ((m_pend > 0) == m_dir) begin
                emit = 1'b1;
                npl  = P + S;
            end else begin
                ndir = (m_pend > 0);
                nsl  = D;
            end
        end
        p   = m_pend - (emit ? (m_dir ? 1 : -1) : 0);
        req = enable && step_in && !m_prev;
        if (req) begin
            s = p + (dir_in ? 1 : -1);
            if (s > LIM || s < -LIM) m_ovf = 1'b1;
            else                     p = s;
        end
        if (!enable) p = 0;
        if (emit) m_pos = m_pos + (m_dir ? 32'd1 : 32'hFFFF_FFFF);
        m_pend       = p;
        m_dir        = ndir;
        m_pulse_left = npl;
        m_setup_left = nsl;
        m_prev       = step_in;
    endtask

    task automatic compare_all();
        check("step_out", 32'(step_out), 32'(m_pulse_left > S));
        check("dir_out",  32'(dir_out),  32'(m_dir));
        check("pending",  32'(pending),  32'(m_pend));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("position", 32'(position), m_pos);
        check("busy",     32'(busy),     32'(m_pulse_left > 0 || m_setup_left > 0));
    endtask

    // One clock: model advances on the rising edge, DUT is compared at the falling edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_adv();
        @(negedge clk);
        cyc++;
        compare_all();
        if (step_out && !so_prev) begin
            n_rise++;
            if (first_rise < 0) first_rise = cyc;
        end
        if (step_out) n_high++;
        so_prev = step_out;
    endtask

    task automatic clear_stats();
        n_rise     = 0;
        n_high     = 0;
        first_rise = -1;
    endtask

    task automatic request(input logic d);
        step_in = 1'b1;
        dir_in  = d;
        step();
        step_in = 1'b0;
        step();
    endtask

    logic        so_a   [0:31];
    logic        dir_a  [0:31];
    logic        busy_a [0:31];
    logic [31:0] pos_a  [0:31];
    logic [31:0] pend_a [0:31];

    initial begin
        int max_p;
        int tries;
        rst_n   = 1'b0;
        enable  = 1'b0;
        step_in = 1'b0;
        dir_in  = 1'b0;
        so_prev = 1'b0;
        clear_stats();
        model_reset();
        @(negedge clk);
        repeat (3) step();
        rst_n  = 1'b1;
        enable = 1'b1;
        step();

        // Single +1 request from reset: direction setup then one pulse.
        cyc     = 0;
        step_in = 1'b1;
        dir_in  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            step_in   = 1'b0;
            so_a[k]   = step_out;
            dir_a[k]  = dir_out;
            busy_a[k] = busy;
            pos_a[k]  = position;
            pend_a[k] = 32'(pending);
        end
        check("first_dir_c1",  32'(dir_a[1]),  32'd0);
        check("first_dir_c2",  32'(dir_a[2]),  32'd1);
        check("first_so_c9",   32'(so_a[9]),   32'd0);
        check("first_so_c10",  32'(so_a[10]),  32'd1);
        check("first_so_c13",  32'(so_a[13]),  32'd1);
        check("first_so_c14",  32'(so_a[14]),  32'd0);
        check("first_busy_17", 32'(busy_a[17]), 32'd1);
        check("first_busy_18", 32'(busy_a[18]), 32'd0);
        check("first_pos_18",  pos_a[18],      32'd1);
        check("first_pend_18", pend_a[18],     32'd0);

        // Three requests with direction already positive: no setup, fixed two-cycle latency.
        clear_stats();
        cyc = 0;
        repeat (3) request(1'b1);
        repeat (40) step();
        check("burst3_first_rise", 32'(first_rise), 32'd2);
        check("burst3_rises",      32'(n_rise),     32'd3);
        check("burst3_high_cyc",   32'(n_high),     32'd12);
        check("burst3_pos",        32'(position),   32'd4);

        // +1 then -1 inside the setup window: no pulse at all.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        clear_stats();
        step_in = 1'b1;
        dir_in  = 1'b1;
        step();
        step_in = 1'b0;
        step();
        step();
        request(1'b0);
        repeat (25) step();
        check("cancel_rises", 32'(n_rise),   32'd0);
        check("cancel_pos",   32'(position), 32'd0);
        check("cancel_pend",  32'(pending),  32'd0);
        check("cancel_busy",  32'(busy),     32'd0);
        check("cancel_dir",   32'(dir_out),  32'd1);

        // Enable dropped at the start of a pulse with three steps still queued.
        clear_stats();
        repeat (5) request(1'b1);
        tries = 0;
        while (n_rise < 2 && tries < 30) begin
            step();
            tries++;
        end
        check("endrop_reached", 32'(n_rise), 32'd2);
        check("endrop_pend_before", 32'(pending), 32'd3);
        enable = 1'b0;
        step();
        check("endrop_pend_after", 32'(pending), 32'd0);
        repeat (10) step();
        enable = 1'b1;
        repeat (30) step();
        check("endrop_rises", 32'(n_rise), 32'd2);
        check("endrop_high",  32'(n_high), 32'd8);

        // Request burst faster than pulses can drain: saturation and sticky overflow.
        clear_stats();
        max_p = -100;
        for (int r = 0; r < 16; r++) begin
            request(1'b1);
            if (int'(pending) > max_p) max_p = int'(pending);
        end
        check("sat_peak",     32'(max_p),    32'd7);
        check("sat_overflow", 32'(overflow), 32'd1);

        // Reset in the middle of a HIGH phase with step_in held high across release.
        tries = 0;
        while (!step_out && tries < 30) begin
            step();
            tries++;
        end
        check("rst_mid_high_seen", 32'(step_out), 32'd1);
        step_in = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("rst_async_step_out", 32'(step_out), 32'd0);
        check("rst_async_overflow", 32'(overflow), 32'd0);
        check("rst_async_position", 32'(position), 32'd0);
        check("rst_async_busy",     32'(busy),     32'd0);
        model_reset();
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        repeat (10) step();
        check("rst_held_step_pend", 32'(pending), 32'd0);
        check("rst_held_step_busy", 32'(busy),    32'd0);
        step_in = 1'b0;
        step();

        // Randomised traffic: varying request rate, direction bias, enable drops and resets.
        for (int seg = 0; seg < 15; seg++) begin
            int rate;
            int dbias;
            rate  = $urandom_range(1, 10);
            dbias = $urandom_range(0, 100);
            repeat (200) begin
                if ($urandom_range(0, 9) < rate) step_in = ~step_in;
                dir_in = ($urandom_range(0, 99) < dbias);
                enable = ($urandom_range(0, 149) != 0);
                rst_n  = ($urandom_range(0, 999) != 0);
                step();
            end
        end
        rst_n = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
